npc_bpred: RTL

Parametrised successor to the combinational next-PC logic. It owns the fetch PC register and adds a direct-mapped branch target buffer (BTB) with saturating direction counters, so fetch predicts redirects without waiting for D.
Branches and jumps still resolve in D. On a misprediction the block redirects fetch and squashes the F/D register.

---
 rtl/npc_bpred_pkg.sv | 20 ++
 rtl/npc_bpred_if.sv | 34 +++
 rtl/npc_btb_array.sv | 106 ++++++++++
 rtl/npc_bpred.sv | 80 ++++++++
 4 files changed

// File: rtl/npc_bpred_pkg.sv
// Shared definitions for the next-PC / branch-prediction slice:
// control-transfer kinds, default vectors and the sequential-PC helper.
package npc_bpred_pkg;

    typedef enum logic [1:0] {
        CT_NONE = 2'd0,
        CT_BR   = 2'd1,
        CT_J    = 2'd2,
        CT_JR   = 2'd3
    } ct_kind_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;

    // Modulo-2^32 sequential successor; 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/npc_bpred_if.sv
// Fetch/decode control bundle between the pipeline (master) and the
// next-PC predictor (slave).
interface npc_bpred_if;

    logic        stallF;
    logic        exc_req;
    logic        eretD;
    logic [31:0] epc;
    logic        d_valid;
    logic [1:0]  d_kind;
    logic [31:0] d_pc;
    logic        d_taken;
    logic [31:0] d_target;
    logic        d_pred_taken;
    logic [31:0] d_pred_target;
    logic [31:0] pcF;
    logic        pred_takenF;
    logic [31:0] pred_targetF;
    logic        flush_fd;
    logic [31:0] mispred_cnt;

    modport master (
        output stallF, exc_req, eretD, epc, d_valid, d_kind, d_pc, d_taken,
               d_target, d_pred_taken, d_pred_target,
        input  pcF, pred_takenF, pred_targetF, flush_fd, mispred_cnt
    );

    modport slave (
        input  stallF, exc_req, eretD, epc, d_valid, d_kind, d_pc, d_taken,
               d_target, d_pred_taken, d_pred_target,
        output pcF, pred_takenF, pred_targetF, flush_fd, mispred_cnt
    );

endinterface

// File: rtl/npc_btb_array.sv
// Direct-mapped BTB storage: combinational lookup, one read-modify-write
// update port applying the counter/allocation policy, sync valid clear.
module npc_btb_array
    import npc_bpred_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] rd_word,
    output logic        rd_hit,
    output logic        rd_taken,
    output logic [31:0] rd_target,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  ct_kind_e    wr_kind,
    input  logic        wr_taken,
    input  logic [31:0] wr_target
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [IDX-1:0]   rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;

    logic             valid_all  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_all    [BTB_ENTRIES];
    logic [31:0]      target_all [BTB_ENTRIES];
    logic             taken_all  [BTB_ENTRIES];

    assign rd_idx = rd_word[IDX-1:0];
    assign rd_tag = rd_word[29:IDX];
    assign wr_idx = wr_word[IDX-1:0];
    assign wr_tag = wr_word[29:IDX];

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_ent
            localparam logic [IDX-1:0] ENT_IDX = IDX'(gi);

            logic             valid_q, valid_d;
            logic [TAG_W-1:0] tag_q, tag_d;
            logic [31:0]      target_q, target_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             hit_w;

            always_comb begin
                valid_d  = valid_q;
                tag_d    = tag_q;
                target_d = target_q;
                cnt_d    = cnt_q;
                hit_w    = valid_q && (tag_q == wr_tag);
                if (wr_en && (wr_idx == ENT_IDX)) begin
                    if (wr_kind == CT_BR) begin
                        if (hit_w) begin
                            if (wr_taken) begin
                                target_d = wr_target;
                                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                            end else if (cnt_q != '0) begin
                                cnt_d = cnt_q - CNT_ONE;
                            end
                        end else if (wr_taken) begin
                            valid_d  = 1'b1;
                            tag_d    = wr_tag;
                            target_d = wr_target;
                            cnt_d    = CNT_WEAK;
                        end
                    end else if (wr_kind != CT_NONE) begin
                        valid_d  = 1'b1;
                        tag_d    = wr_tag;
                        target_d = wr_target;
                        cnt_d    = CNT_MAX;
                    end
                end
            end

            // A write coinciding with reset is dropped; only valid is cleared.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q  <= valid_d;
                    tag_q    <= tag_d;
                    target_q <= target_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign valid_all[gi]  = valid_q;
            assign tag_all[gi]    = tag_q;
            assign target_all[gi] = target_q;
            assign taken_all[gi]  = cnt_q[CNT_W-1];
        end
    endgenerate

    // Reads see the pre-edge contents, so a same-index update is read-old.
    assign rd_hit    = valid_all[rd_idx] && (tag_all[rd_idx] == rd_tag);
    assign rd_taken  = taken_all[rd_idx];
    assign rd_target = target_all[rd_idx];

endmodule

// File: rtl/npc_bpred.sv
// Fetch PC register with BTB-driven prediction; resolves D control
// transfers, redirects on mispredict/exception/eret and counts mispredicts.
module npc_bpred
    import npc_bpred_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = PC_RESET_DEFAULT,
    parameter logic [31:0] EXC_VEC     = EXC_VEC_DEFAULT,
    parameter int          BTB_ENTRIES = 16,
    parameter int          CNT_W       = 2
) (
    input logic        clk,
    input logic        reset,
    npc_bpred_if.slave bus
);

    logic [31:0] pcF_q, pcF_d;
    logic [31:0] mis_q, mis_d;
    logic        lk_hit, lk_taken;
    logic [31:0] lk_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] act_next, pred_next;
    logic        resolve, mispredict, eret_go;

    npc_btb_array #(
        .BTB_ENTRIES(BTB_ENTRIES),
        .CNT_W      (CNT_W)
    ) u_btb (
        .clk      (clk),
        .reset    (reset),
        .rd_word  (pcF_q[31:2]),
        .rd_hit   (lk_hit),
        .rd_taken (lk_taken),
        .rd_target(lk_target),
        .wr_en    (resolve && !reset),
        .wr_word  (bus.d_pc[31:2]),
        .wr_kind  (ct_kind_e'(bus.d_kind)),
        .wr_taken (bus.d_taken),
        .wr_target(bus.d_target)
    );

    always_comb begin
        pred_taken  = lk_hit && lk_taken;
        pred_target = lk_hit ? lk_target : seq_pc(pcF_q);
        act_next    = bus.d_taken      ? bus.d_target      : seq_pc(bus.d_pc);
        pred_next   = bus.d_pred_taken ? bus.d_pred_target : seq_pc(bus.d_pc);
        resolve     = bus.d_valid && (bus.d_kind != CT_NONE) && !bus.stallF;
        mispredict  = resolve && (act_next != pred_next);
        eret_go     = bus.eretD && !bus.stallF;

        if (bus.exc_req)    pcF_d = EXC_VEC;
        else if (eret_go)   pcF_d = bus.epc;
        else if (mispredict) pcF_d = act_next;
        else if (bus.stallF) pcF_d = pcF_q;
        else if (pred_taken) pcF_d = pred_target;
        else                pcF_d = seq_pc(pcF_q);

        // An exception pre-empts the redirect, so it is not counted.
        mis_d = mis_q;
        if (mispredict && !bus.exc_req && (mis_q != 32'hFFFF_FFFF))
            mis_d = mis_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcF_q <= PC_RESET;
            mis_q <= 32'd0;
        end else begin
            pcF_q <= pcF_d;
            mis_q <= mis_d;
        end
    end

    assign bus.pcF          = pcF_q;
    assign bus.pred_takenF  = pred_taken;
    assign bus.pred_targetF = pred_target;
    assign bus.flush_fd     = !reset && (mispredict || bus.exc_req || eret_go);
    assign bus.mispred_cnt  = mis_q;

endmodule
